// File: rtl/regfile_write_ctrl_pkg.sv
// Shared types and constants for the register-file write controller.
// Holds the FSM state enum, widths, hold limit, R0 index and a mask helper.
package regfile_ctrl_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NREG     = 1 << ADDR_W;
    localparam int MAX_HOLD = 4;
    localparam int HCNT_W   = $clog2(MAX_HOLD + 1);

    localparam logic [ADDR_W-1:0] R0_IDX    = '0;
    localparam logic [HCNT_W-1:0] HOLD_SAT  = HCNT_W'(MAX_HOLD);
    localparam logic [HCNT_W-1:0] HOLD_WARN = HCNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WRITE
    } wstate_e;

    // Every MDU op also owns R0 (remainder / high product).
    function automatic logic [NREG-1:0] dest_mask(
        input logic [ADDR_W-1:0] a
    );
        logic [NREG-1:0] m;
        m         = '0;
        m[a]      = 1'b1;
        m[R0_IDX] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Bundle of writeback, MDU, decode and register-file write-port signals.
// master = pipeline / MDU / file side, slave = the write controller.
interface regfile_write_ctrl_if;
    import regfile_ctrl_pkg::*;

    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              md_req;
    logic [ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0] md_data;
    logic [DATA_W-1:0] md_r0_data;
    logic              md_ack;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] rs_a;
    logic [ADDR_W-1:0] rs_b;
    logic              stall;
    logic              wb_hold;

    logic              RegWrite;
    logic [ADDR_W-1:0] WA1;
    logic [DATA_W-1:0] WD1;
    logic              R0W;
    logic [DATA_W-1:0] R0D;
    logic [NREG-1:0]   busy;

    modport master (
        output wb_req, wb_addr, wb_data,
        output md_req, md_addr, md_data, md_r0_data,
        output issue_valid, issue_addr, rs_a, rs_b,
        input  md_ack, stall, wb_hold,
        input  RegWrite, WA1, WD1, R0W, R0D, busy
    );

    modport slave (
        input  wb_req, wb_addr, wb_data,
        input  md_req, md_addr, md_data, md_r0_data,
        input  issue_valid, issue_addr, rs_a, rs_b,
        output md_ack, stall, wb_hold,
        output RegWrite, WA1, WD1, R0W, R0D, busy
    );

endinterface

// File: rtl/regfile_write_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per register, set wins over clear.
// Ports: set/clear masks in, two read taps and the full vector out.
module reg_scoreboard
    import regfile_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NREG-1:0]   set_mask,
    input  logic [NREG-1:0]   clr_mask,
    input  logic [ADDR_W-1:0] rd_a,
    input  logic [ADDR_W-1:0] rd_b,
    output logic              tap_a,
    output logic              tap_b,
    output logic [NREG-1:0]   busy
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign tap_a = busy[rd_a];
    assign tap_b = busy[rd_b];

endmodule

// File: rtl/regfile_write_ctrl.sv
// Arbitrates the file's general and R0 write ports between WB and the MDU.
// Ports: clk, rst (async, active-low), bus (slave side of the bundle).
module regfile_write_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    regfile_write_ctrl_if.slave bus
);

    wstate_e           state;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] buf_r0;
    logic [HCNT_W-1:0] hold_cnt;

    logic              regwrite_q;
    logic [ADDR_W-1:0] wa1_q;
    logic [DATA_W-1:0] wd1_q;
    logic              r0w_q;
    logic [DATA_W-1:0] r0d_q;

    logic              capture;
    logic              to_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_r0;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   busy_q;
    logic              tap_a;
    logic              tap_b;

    // Entering WRITE straight from IDLE uses the live MDU payload,
    // since the buffer is only being loaded on that same edge.
    always_comb begin
        capture  = (state == IDLE) && bus.md_req;
        to_write = (capture || (state == HOLD)) && !bus.wb_req;
        w_addr   = capture ? bus.md_addr    : buf_addr;
        w_data   = capture ? bus.md_data    : buf_data;
        w_r0     = capture ? bus.md_r0_data : buf_r0;
        set_mask = bus.issue_valid ? dest_mask(bus.issue_addr) : '0;
        clr_mask = (state == WRITE) ? dest_mask(buf_addr) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            buf_addr   <= '0;
            buf_data   <= '0;
            buf_r0     <= '0;
            hold_cnt   <= '0;
            regwrite_q <= 1'b0;
            wa1_q      <= '0;
            wd1_q      <= '0;
            r0w_q      <= 1'b0;
            r0d_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (bus.md_req) begin
                        buf_addr <= bus.md_addr;
                        buf_data <= bus.md_data;
                        buf_r0   <= bus.md_r0_data;
                        state    <= bus.wb_req ? HOLD : WRITE;
                    end
                end
                HOLD: begin
                    if (!bus.wb_req) begin
                        state <= WRITE;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    hold_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // WB always owns the general port; MDU only when it is free.
            if (bus.wb_req) begin
                regwrite_q <= 1'b1;
                wa1_q      <= bus.wb_addr;
                wd1_q      <= bus.wb_data;
                r0w_q      <= 1'b0;
            end else if (to_write) begin
                regwrite_q <= (w_addr != R0_IDX);
                wa1_q      <= w_addr;
                wd1_q      <= w_data;
                r0w_q      <= 1'b1;
                r0d_q      <= w_r0;
            end else begin
                regwrite_q <= 1'b0;
                r0w_q      <= 1'b0;
            end
        end
    end

    reg_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_mask (set_mask),
        .clr_mask (clr_mask),
        .rd_a     (bus.rs_a),
        .rd_b     (bus.rs_b),
        .tap_a    (tap_a),
        .tap_b    (tap_b),
        .busy     (busy_q)
    );

    assign bus.md_ack   = capture;
    assign bus.wb_hold  = (state == HOLD) && (hold_cnt == HOLD_WARN);
    assign bus.stall    = tap_a | tap_b | (bus.issue_valid && (|busy_q));
    assign bus.busy     = busy_q;
    assign bus.RegWrite = regwrite_q;
    assign bus.WA1      = wa1_q;
    assign bus.WD1      = wd1_q;
    assign bus.R0W      = r0w_q;
    assign bus.R0D      = r0d_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: per-cycle vector table plus
// hand sequences for mid-HOLD reset and the decode-holds-MDU stall term.
module tb_regfile_write_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_write_ctrl_if bus ();

    regfile_write_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wbr;
        logic [3:0]  wba;
        logic [15:0] wbd;
        logic        mdr;
        logic [3:0]  mda;
        logic [15:0] mdd;
        logic [15:0] mdr0;
        logic        iv;
        logic [3:0]  ia;
        logic [3:0]  rsa;
        logic [3:0]  rsb;
        logic        ack;
        logic        stl;
        logic        hld;
        logic        rw;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        r0w;
        logic [15:0] r0d;
        logic [15:0] busy;
    } vec_t;

    function automatic vec_t V(
        input int wbr, wba, wbd, mdr, mda, mdd, mdr0,
        input int iv, ia, rsa, rsb, ack, stl, hld,
        input int rw, wa, wd, r0w, r0d, busy
    );
        vec_t v;
        v.wbr  = 1'(wbr);
        v.wba  = 4'(wba);
        v.wbd  = 16'(wbd);
        v.mdr  = 1'(mdr);
        v.mda  = 4'(mda);
        v.mdd  = 16'(mdd);
        v.mdr0 = 16'(mdr0);
        v.iv   = 1'(iv);
        v.ia   = 4'(ia);
        v.rsa  = 4'(rsa);
        v.rsb  = 4'(rsb);
        v.ack  = 1'(ack);
        v.stl  = 1'(stl);
        v.hld  = 1'(hld);
        v.rw   = 1'(rw);
        v.wa   = 4'(wa);
        v.wd   = 16'(wd);
        v.r0w  = 1'(r0w);
        v.r0d  = 16'(r0d);
        v.busy = 16'(busy);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.wb_req      = v.wbr;
        bus.wb_addr     = v.wba;
        bus.wb_data     = v.wbd;
        bus.md_req      = v.mdr;
        bus.md_addr     = v.mda;
        bus.md_data     = v.mdd;
        bus.md_r0_data  = v.mdr0;
        bus.issue_valid = v.iv;
        bus.issue_addr  = v.ia;
        bus.rs_a        = v.rsa;
        bus.rs_b        = v.rsb;
    endtask

    task automatic idle();
        apply(V(0,0,0, 0,0,0,0, 0,0, 1,2, 0,0,0, 0,0,0, 0,0, 0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rw"},   32'(bus.RegWrite), 0);
        chk({tag, "_wa"},   32'(bus.WA1), 0);
        chk({tag, "_wd"},   32'(bus.WD1), 0);
        chk({tag, "_r0w"},  32'(bus.R0W), 0);
        chk({tag, "_r0d"},  32'(bus.R0D), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_ack"},  32'(bus.md_ack), 0);
        chk({tag, "_hold"}, 32'(bus.wb_hold), 0);
    endtask

    // WB must never target a register still owed an MDU result.
    always @(negedge clk) begin
        if (rst && bus.wb_req)
            chk("wb_busy", 32'(bus.busy[bus.wb_addr]), 0);
    end

    vec_t tab[29];

    initial begin
        checks   = 0;
        failures = 0;

        // wbr,wba,wbd, mdr,mda,mdd,mdr0, iv,ia, rsa,rsb,
        // ack,stl,hld, rw,wa,wd, r0w,r0d, busy
        tab[0]  = V(1,3,'h1234, 0,0,0,0, 0,0, 1,2, 0,0,0, 0,0,0, 0,0, 0);
        tab[1]  = V(0,0,0, 0,0,0,0, 0,0, 1,2, 0,0,0, 1,3,'h1234, 0,0, 0);
        tab[2]  = V(0,0,0, 0,0,0,0, 1,5, 1,2, 0,0,0, 0,0,0, 0,0, 0);
        tab[3]  = V(0,0,0, 1,5,'h00AA,'h0001, 0,0, 5,0,
                    1,1,0, 0,0,0, 0,0, 'h0021);
        tab[4]  = V(0,0,0, 0,0,0,0, 0,0, 5,0,
                    0,1,0, 1,5,'h00AA, 1,'h0001, 'h0021);
        tab[5]  = V(0,0,0, 0,0,0,0, 0,0, 5,0, 0,0,0, 0,0,0, 0,0, 0);
        tab[6]  = V(0,0,0, 0,0,0,0, 1,0, 1,2, 0,0,0, 0,0,0, 0,0, 0);
        tab[7]  = V(0,0,0, 1,0,'h1111,'hBEEF, 0,0, 0,0,
                    1,1,0, 0,0,0, 0,0, 'h0001);
        tab[8]  = V(0,0,0, 0,0,0,0, 0,0, 0,0,
                    0,1,0, 0,0,0, 1,'hBEEF, 'h0001);
        tab[9]  = V(0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0,0, 0);
        tab[10] = V(1,0,'h5555, 0,0,0,0, 0,0, 1,2, 0,0,0, 0,0,0, 0,0, 0);
        tab[11] = V(0,0,0, 0,0,0,0, 0,0, 1,2, 0,0,0, 1,0,'h5555, 0,0, 0);
        tab[12] = V(0,0,0, 0,0,0,0, 1,7, 1,2, 0,0,0, 0,0,0, 0,0, 0);
        tab[13] = V(0,0,0, 1,7,'h7777,'h0007, 0,0, 7,1,
                    1,1,0, 0,0,0, 0,0, 'h0081);
        tab[14] = V(0,0,0, 0,0,0,0, 1,7, 7,1,
                    0,1,0, 1,7,'h7777, 1,'h0007, 'h0081);
        tab[15] = V(0,0,0, 0,0,0,0, 0,0, 7,1, 0,1,0, 0,0,0, 0,0, 'h0081);
        tab[16] = V(0,0,0, 1,7,'h0102,'h0304, 0,0, 7,1,
                    1,1,0, 0,0,0, 0,0, 'h0081);
        tab[17] = V(0,0,0, 0,0,0,0, 0,0, 7,1,
                    0,1,0, 1,7,'h0102, 1,'h0304, 'h0081);
        tab[18] = V(0,0,0, 0,0,0,0, 0,0, 7,1, 0,0,0, 0,0,0, 0,0, 0);
        tab[19] = V(0,0,0, 0,0,0,0, 1,2, 3,3, 0,0,0, 0,0,0, 0,0, 0);
        tab[20] = V(1,4,'h4444, 1,2,'hABCD,'h0F0F, 0,0, 3,3,
                    1,0,0, 0,0,0, 0,0, 'h0005);
        tab[21] = V(1,4,'h4445, 0,0,0,0, 0,0, 3,3,
                    0,0,0, 1,4,'h4444, 0,0, 'h0005);
        tab[22] = V(1,4,'h4446, 0,0,0,0, 0,0, 3,3,
                    0,0,0, 1,4,'h4445, 0,0, 'h0005);
        tab[23] = V(1,4,'h4447, 0,0,0,0, 0,0, 3,3,
                    0,0,0, 1,4,'h4446, 0,0, 'h0005);
        tab[24] = V(1,4,'h4448, 0,0,0,0, 0,0, 3,3,
                    0,0,1, 1,4,'h4447, 0,0, 'h0005);
        tab[25] = V(0,0,0, 0,0,0,0, 0,0, 3,3,
                    0,0,0, 1,4,'h4448, 0,0, 'h0005);
        tab[26] = V(1,6,'h6666, 0,0,0,0, 0,0, 3,3,
                    0,0,0, 1,2,'hABCD, 1,'h0F0F, 'h0005);
        tab[27] = V(0,0,0, 0,0,0,0, 0,0, 3,3,
                    0,0,0, 1,6,'h6666, 0,0, 0);
        tab[28] = V(0,0,0, 0,0,0,0, 0,0, 3,3, 0,0,0, 0,0,0, 0,0, 0);

        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("por");
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 29; i++) begin
            apply(tab[i]);
            @(negedge clk);
            chk($sformatf("r%0d_ack", i),  32'(bus.md_ack),   32'(tab[i].ack));
            chk($sformatf("r%0d_stall", i), 32'(bus.stall),   32'(tab[i].stl));
            chk($sformatf("r%0d_hold", i), 32'(bus.wb_hold),  32'(tab[i].hld));
            chk($sformatf("r%0d_rw", i),   32'(bus.RegWrite), 32'(tab[i].rw));
            chk($sformatf("r%0d_r0w", i),  32'(bus.R0W),      32'(tab[i].r0w));
            chk($sformatf("r%0d_busy", i), 32'(bus.busy),     32'(tab[i].busy));
            if (tab[i].rw) begin
                chk($sformatf("r%0d_wa", i), 32'(bus.WA1), 32'(tab[i].wa));
                chk($sformatf("r%0d_wd", i), 32'(bus.WD1), 32'(tab[i].wd));
            end
            if (tab[i].r0w)
                chk($sformatf("r%0d_r0d", i), 32'(bus.R0D), 32'(tab[i].r0d));
            @(posedge clk);
            #1;
        end

        // Decode holding an MDU op stalls while anything is busy.
        apply(V(0,0,0, 0,0,0,0, 1,8, 1,2, 0,0,0, 0,0,0, 0,0, 0));
        @(negedge clk);
        chk("s1_stall", 32'(bus.stall), 0);
        @(posedge clk);
        #1;
        apply(V(1,4,'h4A4A, 1,8,'h8888,'h0808, 1,9, 1,2,
                0,0,0, 0,0,0, 0,0, 0));
        @(negedge clk);
        chk("s2_stall", 32'(bus.stall), 1);
        chk("s2_ack", 32'(bus.md_ack), 1);
        chk("s2_busy", 32'(bus.busy), 'h0101);
        @(posedge clk);
        #1;
        apply(V(1,4,'h4B4B, 0,0,0,0, 0,0, 1,2, 0,0,0, 0,0,0, 0,0, 0));
        @(negedge clk);
        chk("s3_rw", 32'(bus.RegWrite), 1);
        chk("s3_wd", 32'(bus.WD1), 'h4A4A);
        chk("s3_busy", 32'(bus.busy), 'h0301);
        chk("s3_ack", 32'(bus.md_ack), 0);

        // Asynchronous reset while the MDU result sits in HOLD.
        #2 rst = 1'b0;
        #1;
        chk_all_zero("mid");
        chk("mid_stall", 32'(bus.stall), 0);
        @(posedge clk);
        #1;
        idle();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post%0d_rw", k), 32'(bus.RegWrite), 0);
            chk($sformatf("post%0d_r0w", k), 32'(bus.R0W), 0);
            chk($sformatf("post%0d_busy", k), 32'(bus.busy), 0);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
